// File: rtl/pnr_bus_pkg.sv
// Shared definitions for the PNR system-bus initiator and the PNR register
// banks: FSM state encoding, default bus widths and register addresses.
package pnr_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } bus_state_t;

   localparam int PNR_ADDR_W = 32;
   localparam int PNR_DATA_W = 32;

   // Register map shared with the PNR register bank
   localparam logic [31:0] PNR_ADDR_LED  = 32'h0000_0000;
   localparam logic [31:0] PNR_ADDR_THR1 = 32'h0000_0001;
   localparam logic [31:0] PNR_ADDR_THR2 = 32'h0000_0002;
   localparam logic [31:0] PNR_ADDR_THR3 = 32'h0000_0003;
   localparam logic [31:0] PNR_ADDR_THR4 = 32'h0000_0004;
   localparam logic [31:0] PNR_ADDR_THR5 = 32'h0000_0005;
   localparam logic [31:0] PNR_ADDR_THR6 = 32'h0000_0006;
   localparam logic [31:0] PNR_ADDR_THR7 = 32'h0000_0007;

endpackage

// File: rtl/pnr_bus_timeout_cnt.sv
// Timeout counter for the bus initiator: cleared outside the wait phase,
// counts while enabled, flags when it sits on the terminal value.
module pnr_bus_timeout_cnt #(
   parameter int CNT_W = 8,
   parameter int TERM  = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CNT_W-1:0] cnt_reg;

   // Clear has priority so every wait phase starts counting from zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_reg <= '0;
      end else if (clr_i) begin
         cnt_reg <= '0;
      end else if (en_i) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign tc_o = (cnt_reg == CNT_W'(TERM));

endmodule

// File: rtl/pnr_sys_bus_initiator.sv
// Red Pitaya system-bus initiator for the PNR register banks.
// One command at a time: strobe, wait for ack or timeout, return response.
// Optional statistics counters are built when PNR_BUS_INIT_STATS_EN is defined.
module pnr_sys_bus_initiator
   import pnr_bus_pkg::*;
#(
   parameter int ADDR_W         = PNR_ADDR_W,
   parameter int DATA_W         = PNR_DATA_W,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_timeout_o,
   output logic [ADDR_W-1:0] sys_addr,
   output logic [DATA_W-1:0] sys_wdata,
   output logic              sys_wen,
   output logic              sys_ren,
   input  logic [DATA_W-1:0] sys_rdata,
   input  logic              sys_err,
   input  logic              sys_ack
`ifdef PNR_BUS_INIT_STATS_EN
   ,
   output logic [31:0]       stat_txn_o,
   output logic [15:0]       stat_timeout_o,
   output logic [15:0]       stat_err_o
`endif
);

   bus_state_t state_reg;
   logic       we_reg;
   logic       cnt_tc;

   // Counter only runs in WAIT; any other state holds it at zero
   pnr_bus_timeout_cnt #(
      .CNT_W (CNT_W),
      .TERM  (TIMEOUT_CYCLES - 1)
   ) u_timeout_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (state_reg != WAIT),
      .en_i  (state_reg == WAIT),
      .tc_o  (cnt_tc)
   );

   // Transaction FSM; every output is a register so sys_ack never reaches a strobe combinationally
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         we_reg        <= 1'b0;
         cmd_ready_o   <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
         sys_addr      <= '0;
         sys_wdata     <= '0;
         sys_wen       <= 1'b0;
         sys_ren       <= 1'b0;
      end else begin
         sys_wen <= 1'b0;
         sys_ren <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  we_reg      <= cmd_we_i;
                  sys_addr    <= cmd_addr_i;
                  sys_wdata   <= cmd_wdata_i;
                  sys_wen     <= cmd_we_i;
                  sys_ren     <= !cmd_we_i;
                  cmd_ready_o <= 1'b0;
                  state_reg   <= ISSUE;
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end
            ISSUE: begin
               // Strobe is high for exactly this cycle; an ack here is ignored
               state_reg <= WAIT;
            end
            WAIT: begin
               if (sys_ack) begin
                  rsp_rdata_o   <= we_reg ? '0 : sys_rdata;
                  rsp_err_o     <= sys_err;
                  rsp_timeout_o <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  state_reg     <= RESP;
               end else if (cnt_tc) begin
                  rsp_rdata_o   <= '0;
                  rsp_err_o     <= 1'b0;
                  rsp_timeout_o <= 1'b1;
                  rsp_valid_o   <= 1'b1;
                  state_reg     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o   <= 1'b0;
                  rsp_rdata_o   <= '0;
                  rsp_err_o     <= 1'b0;
                  rsp_timeout_o <= 1'b0;
                  cmd_ready_o   <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef PNR_BUS_INIT_STATS_EN
   logic rsp_fire;
   assign rsp_fire = rsp_valid_o && rsp_ready_i;

   // Saturating statistics, updated when a response is consumed
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_txn_o     <= '0;
         stat_timeout_o <= '0;
         stat_err_o     <= '0;
      end else if (rsp_fire) begin
         if (stat_txn_o != '1) begin
            stat_txn_o <= stat_txn_o + 1'b1;
         end
         if (rsp_timeout_o && (stat_timeout_o != '1)) begin
            stat_timeout_o <= stat_timeout_o + 1'b1;
         end
         if (rsp_err_o && (stat_err_o != '1)) begin
            stat_err_o <= stat_err_o + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pnr_sys_bus_initiator.sv
// Self-checking bench for pnr_sys_bus_initiator with a register responder
// model on the system bus and a transaction-level expectation model.
module tb_pnr_sys_bus_initiator;
   import pnr_bus_pkg::*;

   localparam int TO = 16;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_we_i = 1'b0;
   logic [31:0] cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic        rsp_ready_i = 1'b0;
   logic        cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o;
   logic [31:0] rsp_rdata_o;
   logic [31:0] sys_addr, sys_wdata;
   logic        sys_wen, sys_ren;
   logic [31:0] sys_rdata = '0;
   logic        sys_err = 1'b0;
   logic        sys_ack;
   logic        resp_ack = 1'b0;
   logic        stray_ack = 1'b0;
`ifdef PNR_BUS_INIT_STATS_EN
   logic [31:0] stat_txn_o;
   logic [15:0] stat_timeout_o, stat_err_o;
`endif

   assign sys_ack = resp_ack | stray_ack;

   always #5 clk_i = ~clk_i;

   pnr_sys_bus_initiator #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(8)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
      .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
`ifdef PNR_BUS_INIT_STATS_EN
      , .stat_txn_o(stat_txn_o), .stat_timeout_o(stat_timeout_o), .stat_err_o(stat_err_o)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
         $error("%s differs", tag);
      end
   endtask

   // ---------------- responder model (registered ack after ack_delay cycles) ----------------
   int          ack_delay = 1;   // 0 = never acknowledge
   logic        ack_err = 1'b0;
   int          cd = 0;
   logic [31:0] pend_rdata = '0;
   logic        pend_err = 1'b0;
   logic [31:0] resp_mem [0:7];

   initial begin
      for (int i = 0; i < 8; i++) resp_mem[i] = '0;
   end

   always @(posedge clk_i) begin
      logic        s_strobe, s_wen;
      logic [31:0] s_addr, s_wdata;
      s_strobe = sys_wen | sys_ren;
      s_wen    = sys_wen;
      s_addr   = sys_addr;
      s_wdata  = sys_wdata;
      #1;
      resp_ack  = 1'b0;
      sys_err   = 1'b0;
      sys_rdata = '0;
      if (rst_i) begin
         cd = 0;
      end else begin
         if (s_strobe) begin
            if (s_wen) begin
               if (s_addr < 8) resp_mem[s_addr[2:0]] = s_wdata;
               pend_rdata = $urandom;   // junk: the initiator must report 0 for writes
            end else begin
               pend_rdata = (s_addr < 8) ? resp_mem[s_addr[2:0]] : 32'h0;
            end
            pend_err = ack_err;
            cd = ack_delay;
         end
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               resp_ack  = 1'b1;
               sys_rdata = pend_rdata;
               sys_err   = pend_err;
            end
         end
      end
   end

   // ---------------- strobe monitor ----------------
   int          strobe_cnt = 0;
   int          both_cnt = 0;
   logic        last_we = 1'b0;
   logic [31:0] last_addr = '0, last_wdata = '0;

   always @(negedge clk_i) begin
      if (sys_wen || sys_ren) begin
         strobe_cnt++;
         last_we    = sys_wen;
         last_addr  = sys_addr;
         last_wdata = sys_wdata;
      end
      if (sys_wen && sys_ren) both_cnt++;
   end

   // ---------------- expectation model ----------------
   logic [31:0] model_mem [0:7];
   int          exp_txn = 0, exp_to = 0, exp_err = 0;
   int          txn_no = 0;

   // One complete transaction. delay: cycles from strobe to ack (0 = never).
   // hold: cycles rsp_ready is withheld while a new command and a stray ack are offered.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic err, input int hold, input logic stray_issue);
      int          lat;
      int          s0;
      logic        acked;
      logic [31:0] exp_rd;
      logic [31:0] snap_rd;
      logic        snap_err, snap_to;

      acked  = (delay >= 1) && (delay <= TO);
      exp_rd = (!we && acked && addr < 8) ? model_mem[addr[2:0]] : 32'h0;
      if (we && addr < 8) model_mem[addr[2:0]] = wdata;
      ack_delay = delay;
      ack_err   = err;
      s0 = strobe_cnt;

      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata;
      lat = 0;
      while (!cmd_ready_o && lat < 20) begin
         @(negedge clk_i);
         lat++;
      end
      check("cmd_ready_idle", {31'b0, cmd_ready_o}, 32'd1);

      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      lat = 1;
      if (stray_issue) stray_ack = 1'b1;
      check("cmd_ready_busy", {31'b0, cmd_ready_o}, 32'd0);
      while (!rsp_valid_o && lat < 40) begin
         @(negedge clk_i);
         stray_ack = 1'b0;
         lat++;
      end
      stray_ack = 1'b0;

      check("latency", lat, acked ? delay + 2 : TO + 2);
      check("rsp_rdata", rsp_rdata_o, exp_rd);
      check("rsp_err", {31'b0, rsp_err_o}, {31'b0, acked && err});
      check("rsp_timeout", {31'b0, rsp_timeout_o}, {31'b0, !acked});
      check("strobe_count", strobe_cnt - s0, 32'd1);
      check("strobe_kind", {31'b0, last_we}, {31'b0, we});
      check("strobe_addr", last_addr, addr);
      if (we) check("strobe_wdata", last_wdata, wdata);

      snap_rd = rsp_rdata_o; snap_err = rsp_err_o; snap_to = rsp_timeout_o;
      for (int i = 0; i < hold; i++) begin
         cmd_valid_i = 1'b1; cmd_we_i = !we; cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
         stray_ack = (i == 2);
         @(negedge clk_i);
         check("hold_ready", {31'b0, cmd_ready_o}, 32'd0);
         check("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
         check("hold_rdata", rsp_rdata_o, snap_rd);
         check("hold_flags", {30'b0, rsp_err_o, rsp_timeout_o}, {30'b0, snap_err, snap_to});
         check("hold_strobes", strobe_cnt - s0, 32'd1);
         check("hold_addr", sys_addr, addr);
      end
      cmd_valid_i = 1'b0;
      stray_ack = 1'b0;

      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      exp_txn++;
      if (!acked) exp_to++;
      if (acked && err) exp_err++;
      check("rsp_cleared", {29'b0, rsp_valid_o, rsp_err_o, rsp_timeout_o}, 32'd0);
      check("rsp_rdata_cleared", rsp_rdata_o, 32'd0);
      check("ready_after", {31'b0, cmd_ready_o}, 32'd1);
      $display("txn %0d we=%0d addr=0x%08h wdata=0x%08h delay=%0d err=%0d -> rdata=0x%08h latency=%0d",
               txn_no, we, addr, wdata, delay, err, snap_rd, lat);
      txn_no++;
   endtask

   task automatic check_stats();
`ifdef PNR_BUS_INIT_STATS_EN
      check("stat_txn", stat_txn_o, exp_txn);
      check("stat_timeout", {16'b0, stat_timeout_o}, exp_to);
      check("stat_err", {16'b0, stat_err_o}, exp_err);
`endif
   endtask

   // ---------------- directed + randomized sequence ----------------
   initial begin
      int          dl [0:8];
      int          s0;
      logic        rw;
      logic [31:0] ra;
      dl = '{1, 1, 1, 2, 4, 9, 16, 17, 0};
      for (int i = 0; i < 8; i++) model_mem[i] = '0;

      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("reset_ready", {31'b0, cmd_ready_o}, 32'd0);
      check("reset_rsp", {29'b0, rsp_valid_o, rsp_err_o, rsp_timeout_o}, 32'd0);
      check("reset_strobes", {30'b0, sys_wen, sys_ren}, 32'd0);
      check("reset_addr", sys_addr, 32'd0);
      check_stats();
      rst_i = 1'b0;

      do_txn(1'b1, PNR_ADDR_LED, 32'h0000_00A5, 1, 1'b0, 0, 1'b0);
      check("led_register", resp_mem[0], 32'h0000_00A5);
      do_txn(1'b1, PNR_ADDR_THR3, 32'h0000_1234, 1, 1'b0, 0, 1'b0);
      do_txn(1'b0, PNR_ADDR_THR3, 32'h0, 1, 1'b0, 0, 1'b0);
      do_txn(1'b0, 32'h9, 32'h0, 1, 1'b0, 0, 1'b0);
      do_txn(1'b0, PNR_ADDR_THR2, 32'h0, 0, 1'b0, 0, 1'b0);          // timeout
      do_txn(1'b0, PNR_ADDR_THR3, 32'h0, 2, 1'b0, 0, 1'b0);          // recovers
      do_txn(1'b1, PNR_ADDR_THR5, 32'hDEAD_BEEF, 1, 1'b1, 0, 1'b0);  // sys_err
      do_txn(1'b0, PNR_ADDR_THR5, 32'h0, TO, 1'b0, 0, 1'b0);         // ack on last wait cycle
      do_txn(1'b0, PNR_ADDR_THR3, 32'h0, 3, 1'b0, 5, 1'b1);          // backpressure, stray acks
      check_stats();

      for (int i = 0; i < 40; i++) begin
         rw = $urandom_range(0, 1);
         ra = $urandom_range(0, 9);
         do_txn(rw, ra, $urandom, dl[$urandom_range(0, 8)], ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0) ? 3 : 0, $urandom_range(0, 1));
      end
      check_stats();

      // Reset in the middle of a WAIT that would otherwise time out
      ack_delay = 0;
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = PNR_ADDR_THR6; cmd_wdata_i = '0;
      for (int k = 0; k < 20 && !cmd_ready_o; k++) @(negedge clk_i);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check("async_rst_ready", {31'b0, cmd_ready_o}, 32'd0);
      check("async_rst_rsp", {29'b0, rsp_valid_o, rsp_err_o, rsp_timeout_o}, 32'd0);
      check("async_rst_rdata", rsp_rdata_o, 32'd0);
      check("async_rst_addr", sys_addr, 32'd0);
      check("async_rst_strobes", {30'b0, sys_wen, sys_ren}, 32'd0);
      exp_txn = 0; exp_to = 0; exp_err = 0;
      check_stats();
      s0 = strobe_cnt;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (4) @(negedge clk_i);
      check("no_reissue", strobe_cnt - s0, 32'd0);
      do_txn(1'b0, PNR_ADDR_THR1, 32'h0, 1, 1'b0, 0, 1'b0);
      check_stats();
      check("dual_strobe", both_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time limit so the bench always ends
   initial begin
      #500000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
